// File: rtl/l2_word_responder_if.sv
// rtl/l2_word_responder_if.sv - L1->L2 word bus between the coherence arbiter (master) and the L2 responder (slave)
interface l2_word_responder_if #(
  parameter int n      = 32,
  parameter int ADDR_W = 15
);
  logic              L2_read_request;
  logic              L2_write_request;
  logic [ADDR_W-1:0] L2_word_address;
  logic [n-1:0]      L2_rdata;
  logic [n-1:0]      L2_wdata;
  logic              L2_busy;
  logic [15:0]       rd_count;
  logic [15:0]       wr_count;

  modport master (
    output L2_read_request, L2_write_request, L2_word_address, L2_rdata,
    input  L2_wdata, L2_busy, rd_count, wr_count
  );

  modport slave (
    input  L2_read_request, L2_write_request, L2_word_address, L2_rdata,
    output L2_wdata, L2_busy, rd_count, wr_count
  );
endinterface

// File: rtl/l2_word_responder.sv
// rtl/l2_word_responder.sv - L2 word store answering one latched read/write per handshake
// with a fixed busy window and saturating read/write statistics.
module l2_word_responder #(
  parameter int n       = 32,
  parameter int ADDR_W  = 15,
  parameter int LATENCY = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  l2_word_responder_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);
  localparam int         DEPTH    = 1 << ADDR_W;

  state_t            r_state;
  state_t            w_next_state;
  logic [3:0]        r_lat_cnt;
  logic              r_op_rd;
  logic              r_op_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [n-1:0]      r_data;
  logic [n-1:0]      r_wdata;
  logic              r_busy;
  logic [15:0]       r_rd_count;
  logic [15:0]       r_wr_count;
  logic [n-1:0]      r_mem [0:DEPTH-1];

  logic w_req;
  logic w_accept;
  logic w_final;

  assign w_req = bus.L2_read_request | bus.L2_write_request;

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_final      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_accept     = 1'b1;
          w_next_state = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_lat_cnt == 4'd0) begin
          w_final      = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        // Wait for the arbiter to drop its request so a held request is not served twice.
        if (!w_req) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_lat_cnt  <= 4'd0;
      r_op_rd    <= 1'b0;
      r_op_wr    <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_rd_count <= 16'd0;
      r_wr_count <= 16'd0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_op_rd   <= bus.L2_read_request;
        r_op_wr   <= bus.L2_write_request;
        r_addr    <= bus.L2_word_address;
        r_data    <= bus.L2_rdata;
        r_lat_cnt <= LAT_LOAD;
        r_busy    <= 1'b1;
      end else if (w_final) begin
        r_busy <= 1'b0;
        // Write-then-read: a combined access returns the word it just stored.
        if (r_op_rd) r_wdata <= r_op_wr ? r_data : r_mem[r_addr];
        if (r_op_rd && (r_rd_count != 16'hFFFF)) r_rd_count <= r_rd_count + 16'd1;
        if (r_op_wr && (r_wr_count != 16'hFFFF)) r_wr_count <= r_wr_count + 16'd1;
      end else if (r_state == S_ACCESS) begin
        r_lat_cnt <= r_lat_cnt - 4'd1;
      end
    end
  end

  // Store has no reset; an aborted access never reaches w_final so nothing is committed.
  always_ff @(posedge i_clk) begin
    if (w_final && r_op_wr) r_mem[r_addr] <= r_data;
  end

  assign bus.L2_wdata = r_wdata;
  assign bus.L2_busy  = r_busy;
  assign bus.rd_count = r_rd_count;
  assign bus.wr_count = r_wr_count;
endmodule

// File: tb/tb_l2_word_responder.sv
// tb/tb_l2_word_responder.sv - randomized self-checking bench for l2_word_responder
// against a transaction-level model of the word store and statistics.
module tb_l2_word_responder;
  localparam int LAT = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  logic [31:0] ref_mem [int unsigned];
  logic [31:0] exp_wdata;
  int          exp_rd;
  int          exp_wr;

  l2_word_responder_if #(.n(32), .ADDR_W(15)) bus ();

  l2_word_responder #(.n(32), .ADDR_W(15), .LATENCY(LAT)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<2000000", $time);
    $fatal(1);
  end

  function automatic void model_apply(input bit rd, input bit wr, input int unsigned addr, input logic [31:0] data);
    if (wr) ref_mem[addr] = data;
    if (rd) exp_wdata = ref_mem[addr];
    if (rd && exp_rd < 65535) exp_rd++;
    if (wr && exp_wr < 65535) exp_wr++;
  endfunction

  function automatic void model_reset();
    exp_wdata = 32'h0;
    exp_rd    = 0;
    exp_wr    = 0;
  endfunction

  task automatic drop_req();
    bus.L2_read_request  = 1'b0;
    bus.L2_write_request = 1'b0;
  endtask

  task automatic wait_busy_rise(output bit to);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.L2_busy === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic count_busy(output int cycles);
    cycles = 0;
    while (bus.L2_busy === 1'b1 && cycles < 50) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic do_access(input bit rd, input bit wr, input logic [14:0] addr, input logic [31:0] data,
                           output int busy_cycles);
    bit to;
    @(negedge clk);
    bus.L2_read_request  = rd;
    bus.L2_write_request = wr;
    bus.L2_word_address  = addr;
    bus.L2_rdata         = data;
    busy_cycles = 0;
    wait_busy_rise(to);
    if (!to) count_busy(busy_cycles);
    drop_req();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drop_req();
    bus.L2_word_address = '0;
    bus.L2_rdata        = '0;
    model_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.L2_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.L2_busy); end
    n_cmp++; if (bus.L2_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", bus.L2_wdata); end
    n_cmp++; if (bus.rd_count !== 16'h0) begin n_fail++; $display("FAIL reset_rd_count got=%h exp=0", bus.rd_count); end
    n_cmp++; if (bus.wr_count !== 16'h0) begin n_fail++; $display("FAIL reset_wr_count got=%h exp=0", bus.wr_count); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int bc;
    do_access(1'b0, 1'b1, 15'h0010, 32'hDEADBEEF, bc);
    model_apply(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    n_cmp++; if (bc != LAT) begin n_fail++; $display("FAIL wr_busy_cycles got=%0d exp=%0d", bc, LAT); end
    n_cmp++; if (bus.wr_count !== 16'(exp_wr)) begin n_fail++; $display("FAIL wr_count got=%0d exp=%0d", bus.wr_count, exp_wr); end
    n_cmp++; if (bus.L2_wdata !== exp_wdata) begin n_fail++; $display("FAIL write_keeps_wdata got=%h exp=%h", bus.L2_wdata, exp_wdata); end
    do_access(1'b1, 1'b0, 15'h0010, 32'hCAFE0000, bc);
    model_apply(1'b1, 1'b0, 32'h10, 32'hCAFE0000);
    n_cmp++; if (bc != LAT) begin n_fail++; $display("FAIL rd_busy_cycles got=%0d exp=%0d", bc, LAT); end
    n_cmp++; if (bus.L2_wdata !== exp_wdata) begin n_fail++; $display("FAIL rd_data got=%h exp=%h", bus.L2_wdata, exp_wdata); end
    n_cmp++; if (bus.rd_count !== 16'(exp_rd)) begin n_fail++; $display("FAIL rd_count got=%0d exp=%0d", bus.rd_count, exp_rd); end
  endtask

  task automatic test_read_write_same();
    int bc;
    do_access(1'b1, 1'b1, 15'h7FFF, 32'h12345678, bc);
    model_apply(1'b1, 1'b1, 32'h7FFF, 32'h12345678);
    n_cmp++; if (bc != LAT) begin n_fail++; $display("FAIL rw_busy_cycles got=%0d exp=%0d", bc, LAT); end
    n_cmp++; if (bus.L2_wdata !== exp_wdata) begin n_fail++; $display("FAIL rw_data got=%h exp=%h", bus.L2_wdata, exp_wdata); end
    n_cmp++; if (bus.rd_count !== 16'(exp_rd)) begin n_fail++; $display("FAIL rw_rd_count got=%0d exp=%0d", bus.rd_count, exp_rd); end
    n_cmp++; if (bus.wr_count !== 16'(exp_wr)) begin n_fail++; $display("FAIL rw_wr_count got=%0d exp=%0d", bus.wr_count, exp_wr); end
  endtask

  task automatic test_held_request();
    bit to;
    int bc;
    int late_busy;
    @(negedge clk);
    bus.L2_write_request = 1'b1;
    bus.L2_word_address  = 15'h0030;
    bus.L2_rdata         = 32'h3C3C_0030;
    bc = 0;
    wait_busy_rise(to);
    if (!to) count_busy(bc);
    model_apply(1'b0, 1'b1, 32'h30, 32'h3C3C_0030);
    late_busy = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.L2_busy !== 1'b0) late_busy++;
      @(negedge clk);
    end
    n_cmp++; if (bc != LAT) begin n_fail++; $display("FAIL held_busy_cycles got=%0d exp=%0d", bc, LAT); end
    n_cmp++; if (late_busy != 0) begin n_fail++; $display("FAIL held_reaccept busy_cycles_after=%0d exp=0", late_busy); end
    n_cmp++; if (bus.wr_count !== 16'(exp_wr)) begin n_fail++; $display("FAIL held_wr_count got=%0d exp=%0d", bus.wr_count, exp_wr); end
    drop_req();
    @(negedge clk);
    do_access(1'b1, 1'b0, 15'h0030, 32'h0, bc);
    model_apply(1'b1, 1'b0, 32'h30, 32'h0);
    n_cmp++; if (bc != LAT) begin n_fail++; $display("FAIL held_next_busy got=%0d exp=%0d", bc, LAT); end
    n_cmp++; if (bus.L2_wdata !== exp_wdata) begin n_fail++; $display("FAIL held_next_data got=%h exp=%h", bus.L2_wdata, exp_wdata); end
  endtask

  task automatic test_input_change();
    bit to;
    int bc;
    do_access(1'b0, 1'b1, 15'h0001, 32'h0BADF00D, bc);
    model_apply(1'b0, 1'b1, 32'h1, 32'h0BADF00D);
    @(negedge clk);
    bus.L2_write_request = 1'b1;
    bus.L2_word_address  = 15'h0002;
    bus.L2_rdata         = 32'h00000055;
    bc = 0;
    wait_busy_rise(to);
    bus.L2_word_address = 15'h0001;
    bus.L2_rdata        = 32'hFFFFFFFF;
    if (!to) count_busy(bc);
    drop_req();
    @(negedge clk);
    model_apply(1'b0, 1'b1, 32'h2, 32'h00000055);
    do_access(1'b1, 1'b0, 15'h0002, 32'h0, bc);
    model_apply(1'b1, 1'b0, 32'h2, 32'h0);
    n_cmp++; if (bus.L2_wdata !== exp_wdata) begin n_fail++; $display("FAIL latched_addr_data got=%h exp=%h", bus.L2_wdata, exp_wdata); end
    do_access(1'b1, 1'b0, 15'h0001, 32'h0, bc);
    model_apply(1'b1, 1'b0, 32'h1, 32'h0);
    n_cmp++; if (bus.L2_wdata !== exp_wdata) begin n_fail++; $display("FAIL untouched_word got=%h exp=%h", bus.L2_wdata, exp_wdata); end
  endtask

  task automatic test_random();
    int bc;
    bit rd;
    bit wr;
    int unsigned addr;
    logic [31:0] data;
    logic [14:0] pool [4];
    pool[0] = 15'h0000;
    pool[1] = 15'h7FFF;
    pool[2] = 15'($urandom_range(0, 32767));
    pool[3] = 15'($urandom_range(0, 32767));
    for (int k = 0; k < 24; k++) begin
      addr = 32'(pool[$urandom_range(0, 3)]);
      data = $urandom;
      case ($urandom_range(0, 2))
        0:       begin rd = 1'b1; wr = 1'b0; end
        1:       begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      if (rd && !wr && !ref_mem.exists(addr)) wr = 1'b1;
      do_access(rd, wr, 15'(addr), data, bc);
      model_apply(rd, wr, addr, data);
      n_cmp++; if (bc != LAT) begin n_fail++; $display("FAIL rand%0d_busy got=%0d exp=%0d", k, bc, LAT); end
      n_cmp++; if (bus.L2_wdata !== exp_wdata) begin n_fail++; $display("FAIL rand%0d_wdata got=%h exp=%h", k, bus.L2_wdata, exp_wdata); end
      n_cmp++; if (bus.rd_count !== 16'(exp_rd)) begin n_fail++; $display("FAIL rand%0d_rd_count got=%0d exp=%0d", k, bus.rd_count, exp_rd); end
      n_cmp++; if (bus.wr_count !== 16'(exp_wr)) begin n_fail++; $display("FAIL rand%0d_wr_count got=%0d exp=%0d", k, bus.wr_count, exp_wr); end
    end
  endtask

  task automatic test_reset_abort();
    bit to;
    int bc;
    do_access(1'b0, 1'b1, 15'h0020, 32'hA5A5A5A5, bc);
    model_apply(1'b0, 1'b1, 32'h20, 32'hA5A5A5A5);
    @(negedge clk);
    bus.L2_write_request = 1'b1;
    bus.L2_word_address  = 15'h0020;
    bus.L2_rdata         = 32'h11111111;
    wait_busy_rise(to);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (bus.L2_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", bus.L2_busy); end
    n_cmp++; if (bus.L2_wdata !== 32'h0) begin n_fail++; $display("FAIL abort_wdata got=%h exp=0", bus.L2_wdata); end
    drop_req();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_access(1'b1, 1'b0, 15'h0020, 32'h0, bc);
    model_apply(1'b1, 1'b0, 32'h20, 32'h0);
    n_cmp++; if (bus.L2_wdata !== exp_wdata) begin n_fail++; $display("FAIL abort_store got=%h exp=%h", bus.L2_wdata, exp_wdata); end
    n_cmp++; if (bus.wr_count !== 16'(exp_wr)) begin n_fail++; $display("FAIL abort_wr_count got=%0d exp=%0d", bus.wr_count, exp_wr); end
    n_cmp++; if (bus.rd_count !== 16'(exp_rd)) begin n_fail++; $display("FAIL abort_rd_count got=%0d exp=%0d", bus.rd_count, exp_rd); end
  endtask

  task automatic test_saturation();
    int bc;
    @(negedge clk);
    force dut.r_rd_count = 16'hFFFE;
    #1;
    release dut.r_rd_count;
    exp_rd = 65534;
    for (int k = 0; k < 3; k++) begin
      do_access(1'b1, 1'b0, 15'h0020, 32'h0, bc);
      model_apply(1'b1, 1'b0, 32'h20, 32'h0);
      n_cmp++; if (bus.rd_count !== 16'(exp_rd)) begin n_fail++; $display("FAIL sat%0d_rd_count got=%h exp=%h", k, bus.rd_count, 16'(exp_rd)); end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_write_read();
    test_read_write_same();
    test_held_request();
    test_input_change();
    test_random();
    test_reset_abort();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
